// File: rtl/mempool_remote_port_scheduler.sv
// Shares a tile's remote request ports between its cores. Ports are assigned
// round-robin and pinned to a core until that core's request handshakes.
module mempool_remote_port_scheduler #(
  parameter int unsigned NumCores = 4,
  parameter int unsigned NumPorts = 4,
  parameter int unsigned SelWidth = (NumPorts + 1 > 1) ? $clog2(NumPorts + 1) : 1,
  localparam int unsigned PrioWidth = (NumCores > 1) ? $clog2(NumCores) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumCores-1:0]                req_valid_i,
  input  logic [NumCores-1:0]                req_local_i,
  input  logic [NumCores-1:0]                req_ready_i,
  output logic [NumCores-1:0]                grant_o,
  output logic [NumCores-1:0][SelWidth-1:0]  tgt_sel_o,
  output logic [NumPorts-1:0]                port_busy_o,
  output logic [PrioWidth-1:0]               priority_o
);

  typedef enum logic {IDLE, HELD} core_state_e;

  core_state_e          state_q     [NumCores];
  logic [SelWidth-1:0]  held_port_q [NumCores];
  logic [PrioWidth-1:0] priority_q, priority_d;

  logic [NumCores-1:0]  is_held, remote_req, hold_active, new_req, new_grant;
  logic [SelWidth-1:0]  new_port [NumCores];
  logic [NumPorts-1:0]  held_mask, free_ports;
  logic                 port_found;
  int unsigned          scan_idx;

  for (genvar gi = 0; gi < NumCores; gi++) begin : g_core
    assign is_held[gi]     = (state_q[gi] == HELD);
    assign remote_req[gi]  = req_valid_i[gi] & ~req_local_i[gi];
    assign hold_active[gi] = is_held[gi] & remote_req[gi];
    assign new_req[gi]     = remote_req[gi] & ~is_held[gi];
    assign grant_o[gi]     = (req_valid_i[gi] & req_local_i[gi]) | hold_active[gi] | new_grant[gi];
    assign tgt_sel_o[gi]   = hold_active[gi] ? held_port_q[gi] :
                             (new_grant[gi] ? new_port[gi] : '0);
  end

  // A HELD core keeps its port reserved for the whole cycle even if it
  // handshakes or drops valid, so released ports only reappear next cycle.
  always_comb begin
    held_mask = '0;
    for (int unsigned c = 0; c < NumCores; c++) begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (is_held[c] && held_port_q[c] == SelWidth'(p + 1)) held_mask[p] = 1'b1;
      end
    end
  end

  always_comb begin
    free_ports = ~held_mask;
    new_grant  = '0;
    priority_d = priority_q;
    port_found = 1'b0;
    scan_idx   = 0;
    for (int unsigned c = 0; c < NumCores; c++) new_port[c] = '0;
    for (int unsigned i = 0; i < NumCores; i++) begin
      scan_idx = i + 32'(priority_q);
      if (scan_idx >= NumCores) scan_idx = scan_idx - NumCores;
      if (new_req[scan_idx]) begin
        port_found = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
          if (!port_found && free_ports[p]) begin
            port_found           = 1'b1;
            free_ports[p]        = 1'b0;
            new_port[scan_idx]   = SelWidth'(p + 1);
          end
        end
        if (port_found) begin
          new_grant[scan_idx] = 1'b1;
          priority_d          = PrioWidth'((scan_idx + 1) % NumCores);
        end
      end
    end
  end

  assign port_busy_o = ~free_ports;
  assign priority_o  = priority_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      priority_q <= '0;
      for (int unsigned c = 0; c < NumCores; c++) begin
        state_q[c]     <= IDLE;
        held_port_q[c] <= SelWidth'(1);
      end
    end else begin
      priority_q <= priority_d;
      for (int unsigned c = 0; c < NumCores; c++) begin
        case (state_q[c])
          HELD: begin
            // Handshake, valid drop or a late local flag all end the hold.
            if (!hold_active[c] || req_ready_i[c]) state_q[c] <= IDLE;
          end
          default: begin
            if (new_grant[c] && !req_ready_i[c]) begin
              state_q[c]     <= HELD;
              held_port_q[c] <= new_port[c];
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mempool_remote_port_scheduler.sv
// Directed bench: instance a has 2 remote ports, instance b has 1 remote port.
module tb_mempool_remote_port_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      va = '0, la = '0, ra = '0, ga;
  logic [3:0][1:0] ta;
  logic [1:0]      ba;
  logic [1:0]      pa;

  logic [3:0]      vb = '0, lb = '0, rb = '0, gb;
  logic [3:0][0:0] tsb;
  logic [0:0]      bb;
  logic [1:0]      pb;

  int checks = 0;
  int errors = 0;

  mempool_remote_port_scheduler #(.NumCores(4), .NumPorts(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(va), .req_local_i(la), .req_ready_i(ra),
    .grant_o(ga), .tgt_sel_o(ta), .port_busy_o(ba), .priority_o(pa)
  );

  mempool_remote_port_scheduler #(.NumCores(4), .NumPorts(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vb), .req_local_i(lb), .req_ready_i(rb),
    .grant_o(gb), .tgt_sel_o(tsb), .port_busy_o(bb), .priority_o(pb)
  );

  task automatic cyc_a(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    va = v; la = l; ra = r;
    #1;
    $display("a: v=%b l=%b r=%b -> g=%b sel=%h busy=%b prio=%0d", v, l, r, ga, ta, ba, pa);
  endtask

  task automatic cyc_b(input logic [3:0] v, input logic [3:0] l, input logic [3:0] r);
    @(negedge clk);
    vb = v; lb = l; rb = r;
    #1;
    $display("b: v=%b l=%b r=%b -> g=%b sel=%b busy=%b prio=%0d", v, l, r, gb, tsb, bb, pb);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ga !== 4'b0000 || ba !== 2'b00 || pa !== 2'd0 || ta !== 8'h00) begin
      errors++;
      $display("FAIL reset_a g=%b busy=%b prio=%0d sel=%h exp g=0000 busy=00 prio=0 sel=00", ga, ba, pa, ta);
    end
    checks++;
    if (gb !== 4'b0000 || bb !== 1'b0 || pb !== 2'd0) begin
      errors++;
      $display("FAIL reset_b g=%b busy=%b prio=%0d exp g=0000 busy=0 prio=0", gb, bb, pb);
    end
  endtask

  task automatic test_local_bypass;
    cyc_b(4'b1111, 4'b0101, 4'b1111);
    checks++;
    if (gb !== 4'b0111 || tsb !== 4'b0010 || bb !== 1'b1) begin
      errors++;
      $display("FAIL local_c0 g=%b sel=%b busy=%b exp g=0111 sel=0010 busy=1", gb, tsb, bb);
    end
    cyc_b(4'b1111, 4'b0101, 4'b1111);
    checks++;
    if (gb !== 4'b1101 || tsb !== 4'b1000 || pb !== 2'd2) begin
      errors++;
      $display("FAIL local_c1 g=%b sel=%b prio=%0d exp g=1101 sel=1000 prio=2", gb, tsb, pb);
    end
    cyc_b(4'b0000, 4'b0000, 4'b0000);
  endtask

  task automatic test_round_robin;
    cyc_a(4'b1111, 4'b0000, 4'b1111);
    checks++;
    if (ga !== 4'b0011 || ta !== {2'd0, 2'd0, 2'd2, 2'd1} || ba !== 2'b11 || pa !== 2'd0) begin
      errors++;
      $display("FAIL rr_c0 g=%b sel=%h busy=%b prio=%0d exp g=0011 sel=09 busy=11 prio=0", ga, ta, ba, pa);
    end
    cyc_a(4'b1111, 4'b0000, 4'b1111);
    checks++;
    if (ga !== 4'b1100 || ta !== {2'd2, 2'd1, 2'd0, 2'd0} || pa !== 2'd2) begin
      errors++;
      $display("FAIL rr_c1 g=%b sel=%h prio=%0d exp g=1100 sel=90 prio=2", ga, ta, pa);
    end
    cyc_a(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pa !== 2'd0 || ga !== 4'b0000) begin
      errors++;
      $display("FAIL rr_wrap prio=%0d g=%b exp prio=0 g=0000", pa, ga);
    end
  endtask

  task automatic test_hold;
    cyc_a(4'b0010, 4'b0000, 4'b0000);
    checks++;
    if (ga !== 4'b0010 || ta !== {2'd0, 2'd0, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL hold_c0 g=%b sel=%h exp g=0010 sel=04", ga, ta);
    end
    cyc_a(4'b0011, 4'b0000, 4'b0001);
    checks++;
    if (ga !== 4'b0011 || ta !== {2'd0, 2'd0, 2'd1, 2'd2} || ba !== 2'b11 || pa !== 2'd2) begin
      errors++;
      $display("FAIL hold_c1 g=%b sel=%h busy=%b prio=%0d exp g=0011 sel=06 busy=11 prio=2", ga, ta, ba, pa);
    end
    cyc_a(4'b0010, 4'b0000, 4'b0000);
    checks++;
    if (ga !== 4'b0010 || ta !== {2'd0, 2'd0, 2'd1, 2'd0} || ba !== 2'b01 || pa !== 2'd1) begin
      errors++;
      $display("FAIL hold_c2 g=%b sel=%h busy=%b prio=%0d exp g=0010 sel=04 busy=01 prio=1", ga, ta, ba, pa);
    end
    cyc_a(4'b1010, 4'b0000, 4'b1010);
    checks++;
    if (ga !== 4'b1010 || ta !== {2'd2, 2'd0, 2'd1, 2'd0} || ba !== 2'b11) begin
      errors++;
      $display("FAIL hold_release g=%b sel=%h busy=%b exp g=1010 sel=84 busy=11", ga, ta, ba);
    end
    cyc_a(4'b1000, 4'b0000, 4'b1000);
    checks++;
    if (ga !== 4'b1000 || ta !== {2'd1, 2'd0, 2'd0, 2'd0} || pa !== 2'd0) begin
      errors++;
      $display("FAIL hold_freed g=%b sel=%h prio=%0d exp g=1000 sel=40 prio=0", ga, ta, pa);
    end
  endtask

  task automatic test_pointer_wrap;
    cyc_a(4'b0100, 4'b0000, 4'b0100);
    cyc_a(4'b1001, 4'b0000, 4'b1001);
    checks++;
    if (pa !== 2'd3 || ga !== 4'b1001 || ta !== {2'd1, 2'd0, 2'd0, 2'd2}) begin
      errors++;
      $display("FAIL wrap_grant prio=%0d g=%b sel=%h exp prio=3 g=1001 sel=42", pa, ga, ta);
    end
    cyc_a(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (pa !== 2'd1) begin
      errors++;
      $display("FAIL wrap_prio prio=%0d exp 1", pa);
    end
  endtask

  task automatic test_valid_drop;
    cyc_a(4'b0110, 4'b0000, 4'b0010);
    checks++;
    if (ga !== 4'b0110 || ta !== {2'd0, 2'd2, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL drop_setup g=%b sel=%h exp g=0110 sel=24", ga, ta);
    end
    cyc_a(4'b0100, 4'b0000, 4'b0000);
    checks++;
    if (ga !== 4'b0100 || ta !== {2'd0, 2'd2, 2'd0, 2'd0} || ba !== 2'b10) begin
      errors++;
      $display("FAIL drop_held g=%b sel=%h busy=%b exp g=0100 sel=20 busy=10", ga, ta, ba);
    end
    cyc_a(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (ga !== 4'b0000 || ta !== 8'h00) begin
      errors++;
      $display("FAIL drop_grant g=%b sel=%h exp g=0000 sel=00", ga, ta);
    end
    cyc_a(4'b0000, 4'b0000, 4'b0000);
    checks++;
    if (ba !== 2'b00) begin
      errors++;
      $display("FAIL drop_busy busy=%b exp 00", ba);
    end
    cyc_a(4'b1001, 4'b0000, 4'b1001);
    checks++;
    if (ga !== 4'b1001 || ta !== {2'd1, 2'd0, 2'd0, 2'd2} || ba !== 2'b11) begin
      errors++;
      $display("FAIL drop_reuse g=%b sel=%h busy=%b exp g=1001 sel=42 busy=11", ga, ta, ba);
    end
  endtask

  task automatic test_reset_mid_hold;
    cyc_a(4'b0110, 4'b0000, 4'b0000);
    cyc_a(4'b0110, 4'b0000, 4'b0000);
    checks++;
    if (ba !== 2'b11 || pa !== 2'd3 || ta !== {2'd0, 2'd2, 2'd1, 2'd0}) begin
      errors++;
      $display("FAIL rst_setup busy=%b prio=%0d sel=%h exp busy=11 prio=3 sel=24", ba, pa, ta);
    end
    va = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ba !== 2'b00 || pa !== 2'd0) begin
      errors++;
      $display("FAIL rst_async busy=%b prio=%0d exp busy=00 prio=0", ba, pa);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc_a(4'b0100, 4'b0000, 4'b0100);
    checks++;
    if (ga !== 4'b0100 || ta !== {2'd0, 2'd1, 2'd0, 2'd0} || pa !== 2'd0) begin
      errors++;
      $display("FAIL rst_after g=%b sel=%h prio=%0d exp g=0100 sel=10 prio=0", ga, ta, pa);
    end
  endtask

  initial begin
    test_reset();
    test_local_bypass();
    test_round_robin();
    test_hold();
    test_pointer_wrap();
    test_valid_drop();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
